decoder_message_handler: RTL

FPGA-side end of the host byte-stream protocol for the single-FPGA Helios decoder. Parses the inbound 8-bit valid/ready stream (start message, measurement header, packed measurement bytes), assembles the full measurement vector, starts the decoding core, and times the decode. When the core finishes, it serializes the result (iteration count, cycle count) onto the outbound 8-bit valid/ready stream. It sits between the host FIFOs and the decoding core inside `Helios_single_FPGA`.

---
 rtl/helios_msg_pkg.sv | 29 ++
 rtl/msg_resp_serializer.sv | 59 +++++
 rtl/decoder_message_handler.sv | 112 +++++++++++
 3 files changed

// File: rtl/helios_msg_pkg.sv
// Shared definitions for the Helios host byte-stream protocol: message codes,
// parse-FSM state encoding and the per-round byte-count helper.
// Optional build macro HELIOS_RESP_CHECKSUM_EN adds a fourth response byte
// (XOR checksum of the first three).
package helios_msg_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

`ifdef HELIOS_RESP_CHECKSUM_EN
    localparam int RESP_BYTES = 4;
`else
    localparam int RESP_BYTES = 3;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_HDR = 3'd1,
        ST_LOAD     = 3'd2,
        ST_DECODE   = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // Bytes needed to carry one round of PU syndrome bits, rounded up.
    function automatic int bytes_per_round(input int pu_per_round);
        return (pu_per_round + 7) / 8;
    endfunction

endpackage

// File: rtl/msg_resp_serializer.sv
// Serializes one decode result (iteration count, cycle count high, cycle count
// low, and with HELIOS_RESP_CHECKSUM_EN an XOR checksum) onto an 8-bit
// valid/ready stream. Flags the acceptance of the final byte to the parent FSM.
module msg_resp_serializer
    import helios_msg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  iteration,
    input  logic [15:0] cycles,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        valid,
    output logic        last_accepted
);

    // Bytes still queued behind the one currently presented on data.
    localparam int TAIL_W = 8 * (RESP_BYTES - 1);

    logic [TAIL_W-1:0] tail;
    logic [TAIL_W-1:0] pending;
    logic [1:0]        left;

`ifdef HELIOS_RESP_CHECKSUM_EN
    assign tail = {cycles, iteration ^ cycles[15:8] ^ cycles[7:0]};
`else
    assign tail = cycles;
`endif

    assign last_accepted = valid && ready && (left == 2'd0);

    // Present bytes one at a time; shift the next one in after each handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            valid   <= 1'b0;
            data    <= 8'h00;
            pending <= '0;
            left    <= 2'd0;
        end else if (load) begin
            valid   <= 1'b1;
            data    <= iteration;
            pending <= tail;
            left    <= 2'(RESP_BYTES - 1);
        end else if (valid && ready) begin
            if (left == 2'd0) begin
                valid <= 1'b0;
                data  <= 8'h00;
            end else begin
                data    <= pending[TAIL_W-1 -: 8];
                pending <= pending << 8;
                left    <= left - 2'd1;
            end
        end
    end

endmodule

// File: rtl/decoder_message_handler.sv
// FPGA-side end of the Helios host protocol: parses start/header/measurement
// bytes, assembles the syndrome vector, launches and times the decoding core,
// then hands the result to the response serializer.
// Optional build macro HELIOS_RESP_CHECKSUM_EN (handled in msg_resp_serializer).
module decoder_message_handler
    import helios_msg_pkg::*;
#(
    parameter int GRID_WIDTH_X            = 6,
    parameter int GRID_WIDTH_Z            = 2,
    parameter int GRID_WIDTH_U            = 9,
    parameter int ITERATION_COUNTER_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         input_data,
    input  logic                               input_valid,
    output logic                               input_ready,
    output logic [7:0]                         output_data,
    output logic                               output_valid,
    input  logic                               output_ready,
    output logic [8*bytes_per_round(GRID_WIDTH_X*GRID_WIDTH_Z)*GRID_WIDTH_U-1:0] measurements,
    output logic                               start_decoding,
    input  logic                               decode_done,
    input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_count
);

    localparam int BYTES_PER_ROUND = bytes_per_round(GRID_WIDTH_X * GRID_WIDTH_Z);
    localparam int TOTAL_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U;
    localparam int IDX_W           = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] byte_idx;
    logic [15:0]      cycle_count;
    logic             accept;
    logic             last_load_byte;
    logic             resp_load;
    logic             resp_last;

    assign accept         = input_valid && input_ready;
    assign last_load_byte = (state == ST_LOAD) && accept &&
                            (byte_idx == IDX_W'(TOTAL_BYTES - 1));
    assign resp_load      = (state == ST_DECODE) && decode_done;

    // Next-state decode of the parse FSM.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        next_state = state;
        case (state)
            ST_IDLE:     if (accept && input_data == START_DECODING_MSG) next_state = ST_WAIT_HDR;
            ST_WAIT_HDR: if (accept && input_data == MEASUREMENT_DATA_HEADER) next_state = ST_LOAD;
            ST_LOAD:     if (last_load_byte) next_state = ST_DECODE;
            ST_DECODE:   if (decode_done) next_state = ST_RESP;
            ST_RESP:     if (resp_last) next_state = ST_WAIT_HDR;
            default:     next_state = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            input_ready    <= 1'b0;
            start_decoding <= 1'b0;
        end else begin
            state          <= next_state;
            input_ready    <= (next_state == ST_IDLE) || (next_state == ST_WAIT_HDR) ||
                              (next_state == ST_LOAD);
            start_decoding <= last_load_byte;
        end
    end

    // Measurement assembly: cleared on header, one byte per accepted LOAD beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the syndrome register is reset because it is a visible output
            // whose reset value is defined, not scratch storage.
            byte_idx     <= '0;
            measurements <= '0;
        end else if (state == ST_WAIT_HDR && next_state == ST_LOAD) begin
            byte_idx     <= '0;
            measurements <= '0;
        end else if (state == ST_LOAD && accept) begin
            measurements[{byte_idx, 3'b000} +: 8] <= input_data;
            byte_idx                              <= byte_idx + 1'b1;
        end
    end

    // Decode timer: cleared when the last byte lands, saturating count while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= 16'h0000;
        end else if (last_load_byte) begin
            cycle_count <= 16'h0000;
        end else if (state == ST_DECODE && !decode_done && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'h0001;
        end
    end

    msg_resp_serializer u_resp (
        .clk           (clk),
        .reset         (reset),
        .load          (resp_load),
        .iteration     (8'(iteration_count)),
        .cycles        (cycle_count),
        .ready         (output_ready),
        .data          (output_data),
        .valid         (output_valid),
        .last_accepted (resp_last)
    );

endmodule
